// File: rtl/sync_pkg.sv
// Shared definitions for the sequential fixed-point multiplier.
//   - DefDataW / DefFracW : default operand width and fractional bit count
//   - state_e             : controller state encoding (IDLE, RUN, NORM, DONE)
package sync_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefFracW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StNorm = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/fx_round_sat.sv
// Combinational normalisation of a 2*DATA_W-bit signed product to DATA_W bits:
// optional round, arithmetic shift right by FRAC_W, then saturation.
// Optional feature macro: SEQMULT_ROUND_EN (add 2^(FRAC_W-1) before the shift,
// round half toward +infinity); when undefined the shift truncates (floor) and
// no adder is built.
// Ports:
//   acc     in  2*DATA_W  signed full-precision product
//   product out DATA_W    normalised, saturated result
//   ovf     out 1         result was clamped
module fx_round_sat import sync_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned FRAC_W = DefFracW
) (
  input  logic [2*DATA_W-1:0] acc,
  output logic [DATA_W-1:0]   product,
  output logic                ovf
);

  localparam int unsigned AccW = 2 * DATA_W;

  logic signed [AccW-1:0] rounded;
  logic signed [AccW-1:0] shifted;
  logic [AccW-DATA_W:0]   upper;

`ifdef SEQMULT_ROUND_EN
  localparam logic [AccW-1:0] Half = {{(AccW-1){1'b0}}, 1'b1} << (FRAC_W - 1);
  // Cannot overflow: |A*B| <= 2^(2*DATA_W-2), far below the accumulator limit.
  assign rounded = $signed(acc + Half);
`else
  assign rounded = $signed(acc);
`endif

  assign shifted = rounded >>> FRAC_W;

  // Bits DATA_W-1 and above must all equal the sign for the value to fit.
  assign upper = shifted[AccW-1:DATA_W-1];

  always_comb begin
    product = shifted[DATA_W-1:0];
    ovf     = 1'b0;
    if (!((&upper) || !(|upper))) begin
      ovf = 1'b1;
      if (shifted[AccW-1]) begin
        product = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        product = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/seqmult_fx.sv
// Sequential signed fixed-point multiplier (shift-and-add, one multiplier bit
// per clock), result = sat((A*B) >> FRAC_W).
// Optional feature macro: SEQMULT_ROUND_EN (round instead of truncate in NORM,
// implemented inside fx_round_sat).
// Ports:
//   clk          in  1       clock, rising edge
//   rst          in  1       synchronous reset, active high
//   start        in  1       request a multiply (sampled in IDLE only)
//   abort        in  1       cancel any operation, back to IDLE
//   multiplicand in  DATA_W  signed operand A
//   multiplier   in  DATA_W  signed operand B
//   busy         out 1       high in every state except IDLE
//   finish       out 1       one-cycle pulse, product/ovf valid
//   product      out DATA_W  registered saturated result
//   ovf          out 1       registered saturation flag
module seqmult_fx import sync_pkg::*; #(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned FRAC_W = DefFracW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic              busy,
  output logic              finish,
  output logic [DATA_W-1:0] product,
  output logic              ovf
);

  localparam int unsigned AccW = 2 * DATA_W;
  localparam int unsigned CntW = $clog2(DATA_W);

  state_e            state;
  logic [CntW-1:0]   counter;
  logic [AccW-1:0]   acc;
  logic [AccW-1:0]   b;
  logic [DATA_W-1:0] q;

  logic [DATA_W-1:0] norm_product;
  logic              norm_ovf;

  fx_round_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_round_sat (
    .acc     (acc),
    .product (norm_product),
    .ovf     (norm_ovf)
  );

  assign busy = (state != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      counter <= '0;
      acc     <= '0;
      b       <= '0;
      q       <= '0;
      product <= '0;
      ovf     <= 1'b0;
      finish  <= 1'b0;
    end else if (abort) begin
      // Results of the last completed operation are deliberately kept.
      state  <= StIdle;
      finish <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          finish <= 1'b0;
          if (start) begin
            b       <= {{DATA_W{multiplicand[DATA_W-1]}}, multiplicand};
            q       <= multiplier;
            acc     <= '0;
            counter <= CntW'(DATA_W - 1);
            state   <= StRun;
          end
        end
        StRun: begin
          // The multiplier MSB has weight -2^(DATA_W-1), hence subtract last.
          if (q[0]) begin
            if (counter == '0) begin
              acc <= acc - b;
            end else begin
              acc <= acc + b;
            end
          end
          b <= b << 1;
          q <= q >> 1;
          if (counter == '0) begin
            state <= StNorm;
          end else begin
            counter <= counter - CntW'(1);
          end
        end
        StNorm: begin
          product <= norm_product;
          ovf     <= norm_ovf;
          finish  <= 1'b1;
          state   <= StDone;
        end
        StDone: begin
          finish <= 1'b0;
          state  <= StIdle;
        end
        default: begin
          finish <= 1'b0;
          state  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seqmult_fx.sv
// Scoreboard bench for seqmult_fx (DATA_W=16, FRAC_W=8): stimulus pushes the
// hand-computed result, a monitor pops and compares on every finish pulse.
module tb_seqmult_fx;

  localparam int unsigned DataW = 16;
  localparam int unsigned FracW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [DataW-1:0] multiplicand = '0;
  logic [DataW-1:0] multiplier = '0;
  logic             busy;
  logic             finish;
  logic [DataW-1:0] product;
  logic             ovf;

  int checks = 0;
  int failures = 0;

  // {ovf, product}
  logic [DataW:0] exp_q[$];

  seqmult_fx #(
    .DATA_W (DataW),
    .FRAC_W (FracW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .finish       (finish),
    .product      (product),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every finish pulse against the oldest expectation.
  initial begin
    logic [DataW:0] e;
    forever begin
      @(negedge clk);
      if (!rst && finish === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_finish: got product %h ovf %b with no operation pending",
                   product, ovf);
        end else begin
          e = exp_q.pop_front();
          check("product", 32'(product), 32'(e[DataW-1:0]));
          check("ovf", 32'(ovf), 32'(e[DataW]));
        end
      end
    end
  end

  // kind: 0 plain, 1 second start at cycle inj, 2 abort at cycle inj
  task automatic run_op(input logic [DataW-1:0] a, input logic [DataW-1:0] bb,
                        input logic [DataW-1:0] exp_p, input logic exp_o,
                        input int kind, input int inj);
    int fin_cyc;
    int busy_cnt;
    logic [DataW-1:0] prev_p;
    logic prev_o;
    prev_p = product;
    prev_o = ovf;
    if (kind != 2) exp_q.push_back({exp_o, exp_p});
    @(negedge clk);
    multiplicand = a;
    multiplier = bb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fin_cyc = 0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 40 && fin_cyc == 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (kind == 1) begin
        start = (cyc == inj);
        if (cyc == inj) begin
          multiplicand = 16'h7F00;
          multiplier = 16'h7F00;
        end
      end
      if (kind == 2) begin
        abort = (cyc == inj);
        if (cyc == inj + 1) begin
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_product", 32'(product), 32'(prev_p));
          check("abort_ovf", 32'(ovf), 32'(prev_o));
        end
      end
      if (finish === 1'b1) fin_cyc = cyc;
      else if (busy === 1'b1) busy_cnt++;
    end
    start = 1'b0;
    abort = 1'b0;
    if (kind == 2) begin
      check("abort_no_finish", 32'(fin_cyc), 32'd0);
    end else begin
      check("latency", 32'(fin_cyc), 32'd18);
      check("busy_cycles", 32'(busy_cnt), 32'd17);
      check("finish_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("finish_one_cycle", 32'(finish), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    run_op(16'h0180, 16'h0200, 16'h0300, 1'b0, 0, 0);
    run_op(16'hFE80, 16'h0200, 16'hFD00, 1'b0, 0, 0);
    run_op(16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 0, 0);
    run_op(16'h7F00, 16'h7F00, 16'h7FFF, 1'b1, 0, 0);
`ifdef SEQMULT_ROUND_EN
    run_op(16'h0001, 16'h0080, 16'h0001, 1'b0, 0, 0);
    run_op(16'hFFFF, 16'h0080, 16'h0000, 1'b0, 0, 0);
`else
    run_op(16'h0001, 16'h0080, 16'h0000, 1'b0, 0, 0);
    run_op(16'hFFFF, 16'h0080, 16'hFFFF, 1'b0, 0, 0);
`endif
    // Negative result that fits, with FRAC bits discarded: -2.0 * 0.75 = -1.5
    run_op(16'hFE00, 16'h00C0, 16'hFE80, 1'b0, 0, 0);

    // Second start during RUN is ignored.
    run_op(16'h0180, 16'h0200, 16'h0300, 1'b0, 1, 5);
    // Abort during RUN, then a normal operation.
    run_op(16'h7F00, 16'h7F00, 16'h0000, 1'b0, 2, 7);
    run_op(16'hFE80, 16'h0200, 16'hFD00, 1'b0, 0, 0);

    // Reset in the middle of RUN.
    @(negedge clk);
    multiplicand = 16'h0180;
    multiplier = 16'h0200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_run_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_finish", 32'(finish), 32'd0);
    check("mid_rst_product", 32'(product), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // start together with abort in IDLE: nothing starts.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    repeat (25) @(negedge clk);

    run_op(16'h0180, 16'h0200, 16'h0300, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
